// File: rtl/simple_bfm_pkg.sv
// Shared types and defaults for the simple_bfm req/ack sink.
// Holds the sink FSM state encoding and default sizes.
package simple_bfm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } sink_state_e;

  localparam int SINK_DATA_W = 8;
  localparam int SINK_DEPTH  = 4;

endpackage

// File: rtl/simple_bfm_sink_fifo.sv
// First-word-fall-through FIFO with extra pointer MSB for full/empty.
// Occupancy is the pointer difference; pointers wrap modulo 2*DEPTH.
module simple_bfm_sink_fifo
  import simple_bfm_pkg::*;
#(
  parameter int DATA_WIDTH = SINK_DATA_W,
  parameter int DEPTH      = SINK_DEPTH,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty,
  output logic [AW:0]           level
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == DEPTH[AW:0]);
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; contents are only visible while non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/simple_bfm_sink.sv
// req/ack consumer for simple_bfm: one ack per transfer, words into a FIFO.
// Define SIMPLE_BFM_SINK_STATS_EN to enable transfer count and XOR checksum.
module simple_bfm_sink
  import simple_bfm_pkg::*;
#(
  parameter int DATA_WIDTH = SINK_DATA_W,
  parameter int DEPTH      = SINK_DEPTH,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_i,
  output logic                     ack_o,
  input  logic [DATA_WIDTH-1:0]    data_i,
  output logic                     out_valid_o,
  output logic [DATA_WIDTH-1:0]    out_data_o,
  input  logic                     out_ready_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [CNT_WIDTH-1:0]     xfer_count_o,
  output logic [DATA_WIDTH-1:0]    checksum_o
);

  sink_state_e state;
  sink_state_e state_next;
  logic        ack_q;
  logic        push;
  logic        full;
  logic        empty;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (req_i && !full) state_next = ACK;
      ACK:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ack_q <= 1'b0;
    end else begin
      state <= state_next;
      ack_q <= (state_next == ACK);
    end
  end

  // Space was reserved by the full check when leaving IDLE.
  assign push        = (state == ACK) && ack_q && req_i;
  assign ack_o       = ack_q;
  assign out_valid_o = !empty;

  simple_bfm_sink_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(data_i),
    .pop      (out_ready_i),
    .head     (out_data_o),
    .full     (full),
    .empty    (empty),
    .level    (level_o)
  );

`ifdef SIMPLE_BFM_SINK_STATS_EN
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [DATA_WIDTH-1:0] sum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      sum_q <= '0;
    end else if (push) begin
      cnt_q <= cnt_q + 1'b1;
      sum_q <= sum_q ^ data_i;
    end
  end

  assign xfer_count_o = cnt_q;
  assign checksum_o   = sum_q;
`else
  assign xfer_count_o = '0;
  assign checksum_o   = '0;
`endif

endmodule

// File: tb/tb_simple_bfm_sink.sv
// Directed bench for simple_bfm_sink with a queue-based output scoreboard.
// Honours SIMPLE_BFM_SINK_STATS_EN for the stats expectations.
module tb_simple_bfm_sink;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        ack;
  logic [7:0]  data = '0;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready = 1'b0;
  logic [2:0]  level;
  logic [31:0] xfer_count;
  logic [7:0]  checksum;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  simple_bfm_sink dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .ack_o       (ack),
    .data_i      (data),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_ready_i (out_ready),
    .level_o     (level),
    .xfer_count_o(xfer_count),
    .checksum_o  (checksum)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every popped word must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %0h expected none", out_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          errors++;
          $display("FAIL pop_data: got %0h expected %0h", out_data, e);
        end
      end
    end
  end

  task automatic xfer(input logic [7:0] d);
    bit seen;
    seen = 0;
    req = 1'b1;
    data = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got 0 expected 1");
    end else begin
      exp_q.push_back(d);
    end
    @(posedge clk);
    #1 req = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0) break;
    end
    #1 out_ready = 1'b0;
    chk("drain_empty", exp_q.size(), 0);
    @(negedge clk);
    chk("drain_level", level, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    req = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit acked;
    // Reset state
    #2;
    chk("rst_ack", ack, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_cnt", xfer_count, 0);
    chk("rst_sum", checksum, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single transfer with exact ack timing
    @(posedge clk);
    #1 req = 1'b1;
    data = 8'h5A;
    @(negedge clk);
    chk("single_pre_ack", ack, 0);
    @(negedge clk);
    chk("single_ack", ack, 1);
    chk("single_valid_early", out_valid, 0);
    exp_q.push_back(8'h5A);
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    chk("single_ack_drop", ack, 0);
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, 8'h5A);
    chk("single_level", level, 1);
    drain();

    // Fill and backpressure
    for (int i = 1; i <= 4; i++) xfer(8'(i));
    @(posedge clk);
    #1 req = 1'b1;
    data = 8'h05;
    acked = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ack) acked = 1;
    end
    chk("full_no_ack", acked, 0);
    chk("full_level", level, 4);
    chk("full_head", out_data, 8'h01);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    acked = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (ack) begin
        acked = 1;
        break;
      end
    end
    chk("fifth_acked", acked, 1);
    if (acked) exp_q.push_back(8'h05);
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    chk("refill_level", level, 4);
    drain();

    // Push and pop on the same edge at level 2
    xfer(8'hA1);
    xfer(8'hB2);
    @(negedge clk);
    chk("pp_level_pre", level, 2);
    @(posedge clk);
    #1 req = 1'b1;
    data = 8'hC3;
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk("pp_ack", ack, 1);
    exp_q.push_back(8'hC3);
    @(posedge clk);
    #1 out_ready = 1'b0;
    req = 1'b0;
    @(negedge clk);
    chk("pp_level_post", level, 2);
    chk("pp_head", out_data, 8'hB2);
    drain();

    // Wrap-around streaming
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) xfer(8'(i));
    drain();

    // Reset during ACK
    @(posedge clk);
    #1 req = 1'b1;
    data = 8'h77;
    acked = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ack) begin
        acked = 1;
        break;
      end
    end
    chk("mid_ack_seen", acked, 1);
    #1 rst = 1'b1;
    #1;
    chk("mid_ack_async", ack, 0);
    req = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_level", level, 0);
    chk("mid_valid", out_valid, 0);
    xfer(8'h3C);
    @(negedge clk);
    chk("mid_recover_level", level, 1);
    drain();

    // Stats from a clean reset
    do_reset();
    xfer(8'h0F);
    xfer(8'hF0);
    xfer(8'hFF);
    @(negedge clk);
`ifdef SIMPLE_BFM_SINK_STATS_EN
    chk("stats_cnt", xfer_count, 3);
`else
    chk("stats_cnt", xfer_count, 0);
`endif
    chk("stats_sum", checksum, 8'h00);
    chk("stats_level", level, 3);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

endmodule
